// File: rtl/sram_block_writer.sv
// Frame writer: buffers 8x1 block rows from the 2D-DCT in a 2-entry FIFO and
// writes them to a single-port SRAM, optionally re-ordering blocks into raster order.
module sram_block_writer #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 15,
  parameter int BLOCK_MAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_cen_n,
  output logic              mem_wen_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_cnt;
  logic [ADDR_W:0]   acc_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              active;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              commit;
  logic              last_accept;
  logic              last_write;

  // Handshake: a row moves on a rising edge with in_valid=1 and in_ready=1;
  // an SRAM write commits on a rising edge with mem_cen_n=0 and mem_gnt=1.
  assign active      = (state == RUN) || (state == FLUSH);
  assign fifo_full   = (fifo_cnt == 2'd2);
  assign fifo_empty  = (fifo_cnt == 2'd0);
  assign in_ready    = (state == RUN) && !fifo_full && !acc_cnt[ADDR_W];
  assign push        = in_valid && in_ready;
  // Reset masks the enable so nothing commits on a reset edge.
  assign mem_cen_n   = !(active && !fifo_empty && !reset);
  assign mem_wen_n   = mem_cen_n;
  assign commit      = !mem_cen_n && mem_gnt;
  assign last_accept = push && (acc_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});
  assign last_write  = commit && (wr_cnt == {ADDR_W{1'b1}});
  assign mem_wdata   = fifo_mem[rd_ptr];
  assign busy        = active;
  assign done        = (state == DONE);
  assign fsm_state   = state;

  // Block b = wr_cnt[ADDR_W-1:3], row r = wr_cnt[2:0]; raster address is
  // {block row, pixel row, block column} with 64 blocks per image row.
  generate
    if (BLOCK_MAP != 0) begin : g_block_map
      assign mem_addr = {wr_cnt[ADDR_W-1:9], wr_cnt[2:0], wr_cnt[8:3]};
    end else begin : g_linear_map
      assign mem_addr = wr_cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fifo_cnt    <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_data;
        wr_ptr           <= ~wr_ptr;
        acc_cnt          <= acc_cnt + 1'b1;
      end
      if (commit) begin
        rd_ptr <= ~rd_ptr;
        wr_cnt <= wr_cnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, commit};
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            fifo_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
          end
        end
        RUN:   if (last_accept) state <= FLUSH;
        // Every row is accepted by now, so an empty FIFO means the frame is written.
        FLUSH: if (last_write || fifo_empty) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
